// File: rtl/dsp_fir_feeder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : dsp_fir_feeder
//  Purpose  : Time-multiplexed single-channel FIR sequencer for an external
//             DSP MAC macro. Holds the sample delay line and coefficient file,
//             issues one MAC operation per tap, captures the accumulated sum
//             and hands it out through a valid/ready result port.
//  Revision : 1.0  initial release
// ============================================================================
module dsp_fir_feeder #(
    parameter int NTAPS   = 8,
    parameter int MAC_LAT = 1
) (
    input  logic        CLOCK,
    input  logic        CLR,
    input  logic [15:0] SAMPLE_IN,
    input  logic        SAMPLE_VLD,
    output logic        SAMPLE_RDY,
    input  logic        COEF_WE,
    input  logic [3:0]  COEF_ADDR,
    input  logic [15:0] COEF_WDATA,
    output logic [31:0] OPER_DATA,
    output logic [31:0] COEF_DATA,
    output logic        DSP_ENABLE,
    output logic        DSP_CLR,
    input  logic [63:0] MAC_OUT,
    output logic [63:0] RESULT,
    output logic        RESULT_VLD,
    input  logic        RESULT_RDY
);

    localparam int TAP_W = $clog2(NTAPS);
    localparam int LAT_W = 3;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_HOLD  = 2'd3;

    localparam logic [TAP_W-1:0] LAST_TAP   = TAP_W'(NTAPS - 1);
    localparam logic [LAT_W-1:0] LAST_DRAIN = LAT_W'(MAC_LAT - 1);
    localparam logic [4:0]       TAP_LIMIT  = 5'(NTAPS);

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [TAP_W-1:0] tap;
    logic [TAP_W-1:0] tap_nxt;
    logic [TAP_W-1:0] tap_inc;
    logic [LAT_W-1:0] drain_cnt;
    logic [LAT_W-1:0] drain_cnt_nxt;

    logic [15:0] delay_line [NTAPS];
    logic [15:0] coef_file  [NTAPS];

    logic        accept;
    logic        coef_wr_ok;
    logic        capture;
    logic [31:0] oper_nxt;
    logic [31:0] coef_nxt;
    logic        enable_nxt;
    logic        clr_nxt;

    // Handshake decodes come straight from the state register so they are glitch-free.
    assign SAMPLE_RDY = (state == ST_IDLE);
    assign RESULT_VLD = (state == ST_HOLD);

    assign accept     = (state == ST_IDLE) && SAMPLE_VLD;
    // Writes are only honoured while no pass is using the coefficient file.
    assign coef_wr_ok = COEF_WE && ((state == ST_IDLE) || (state == ST_HOLD))
                        && ({1'b0, COEF_ADDR} < TAP_LIMIT);
    assign capture    = (state == ST_DRAIN) && (drain_cnt == LAST_DRAIN);
    assign tap_inc    = tap + 1'b1;

    // State register with tap and drain counters.
    always_ff @(posedge CLOCK or posedge CLR) begin
        if (CLR) begin
            state     <= ST_IDLE;
            tap       <= '0;
            drain_cnt <= '0;
        end else begin
            state     <= state_nxt;
            tap       <= tap_nxt;
            drain_cnt <= drain_cnt_nxt;
        end
    end

    // Next-state logic: IDLE -> RUN (NTAPS cycles) -> DRAIN (MAC_LAT cycles) -> HOLD.
    always_comb begin
        state_nxt     = state;
        tap_nxt       = tap;
        drain_cnt_nxt = drain_cnt;
        case (state)
            ST_IDLE: begin
                if (SAMPLE_VLD) begin
                    state_nxt = ST_RUN;
                    tap_nxt   = '0;
                end
            end
            ST_RUN: begin
                if (tap == LAST_TAP) begin
                    state_nxt     = ST_DRAIN;
                    drain_cnt_nxt = '0;
                end else begin
                    tap_nxt = tap_inc;
                end
            end
            ST_DRAIN: begin
                if (drain_cnt == LAST_DRAIN) begin
                    state_nxt = ST_HOLD;
                end else begin
                    drain_cnt_nxt = drain_cnt + 1'b1;
                end
            end
            ST_HOLD: begin
                if (RESULT_RDY) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // MAC pin values for the coming cycle; operands are pre-loaded one edge ahead.
    always_comb begin
        oper_nxt   = '0;
        coef_nxt   = '0;
        enable_nxt = 1'b0;
        clr_nxt    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (SAMPLE_VLD) begin
                    // Tap 0 uses the sample being accepted; a same-edge write to
                    // c[0] is forwarded so the whole pass sees one coefficient set.
                    oper_nxt   = {{16{SAMPLE_IN[15]}}, SAMPLE_IN};
                    if (coef_wr_ok && (COEF_ADDR == 4'd0)) begin
                        coef_nxt = {{16{COEF_WDATA[15]}}, COEF_WDATA};
                    end else begin
                        coef_nxt = {{16{coef_file[0][15]}}, coef_file[0]};
                    end
                    enable_nxt = 1'b1;
                    clr_nxt    = 1'b1;
                end
            end
            ST_RUN: begin
                if (tap != LAST_TAP) begin
                    oper_nxt   = {{16{delay_line[tap_inc][15]}}, delay_line[tap_inc]};
                    coef_nxt   = {{16{coef_file[tap_inc][15]}}, coef_file[tap_inc]};
                    enable_nxt = 1'b1;
                end
            end
            default: begin
                oper_nxt   = '0;
                coef_nxt   = '0;
                enable_nxt = 1'b0;
                clr_nxt    = 1'b0;
            end
        endcase
    end

    // Registered MAC drive and result capture.
    always_ff @(posedge CLOCK or posedge CLR) begin
        if (CLR) begin
            OPER_DATA  <= '0;
            COEF_DATA  <= '0;
            DSP_ENABLE <= 1'b0;
            DSP_CLR    <= 1'b0;
            RESULT     <= '0;
        end else begin
            OPER_DATA  <= oper_nxt;
            COEF_DATA  <= coef_nxt;
            DSP_ENABLE <= enable_nxt;
            DSP_CLR    <= clr_nxt;
            if (capture) begin
                RESULT <= MAC_OUT;
            end
        end
    end

    // Delay line shifts on each accepted sample; coefficient file takes gated writes.
    always_ff @(posedge CLOCK or posedge CLR) begin
        if (CLR) begin
            for (int i = 0; i < NTAPS; i++) begin
                delay_line[i] <= '0;
                coef_file[i]  <= '0;
            end
        end else begin
            if (accept) begin
                delay_line[0] <= SAMPLE_IN;
                for (int i = 1; i < NTAPS; i++) begin
                    delay_line[i] <= delay_line[i-1];
                end
            end
            for (int i = 0; i < NTAPS; i++) begin
                if (coef_wr_ok && (COEF_ADDR == 4'(i))) begin
                    coef_file[i] <= COEF_WDATA;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dsp_fir_feeder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_dsp_fir_feeder
//  Purpose  : Directed self-checking bench for dsp_fir_feeder with NTAPS=4,
//             MAC_LAT=1 and a registered behavioural MAC.
//  Revision : 1.0  initial release
// ============================================================================
module tb_dsp_fir_feeder;

    localparam int NTAPS   = 4;
    localparam int MAC_LAT = 1;

    logic        CLOCK      = 1'b0;
    logic        CLR        = 1'b1;
    logic [15:0] SAMPLE_IN  = '0;
    logic        SAMPLE_VLD = 1'b0;
    logic        SAMPLE_RDY;
    logic        COEF_WE    = 1'b0;
    logic [3:0]  COEF_ADDR  = '0;
    logic [15:0] COEF_WDATA = '0;
    logic [31:0] OPER_DATA;
    logic [31:0] COEF_DATA;
    logic        DSP_ENABLE;
    logic        DSP_CLR;
    logic [63:0] MAC_OUT;
    logic [63:0] RESULT;
    logic        RESULT_VLD;
    logic        RESULT_RDY = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    dsp_fir_feeder #(.NTAPS(NTAPS), .MAC_LAT(MAC_LAT)) dut (
        .CLOCK      (CLOCK),
        .CLR        (CLR),
        .SAMPLE_IN  (SAMPLE_IN),
        .SAMPLE_VLD (SAMPLE_VLD),
        .SAMPLE_RDY (SAMPLE_RDY),
        .COEF_WE    (COEF_WE),
        .COEF_ADDR  (COEF_ADDR),
        .COEF_WDATA (COEF_WDATA),
        .OPER_DATA  (OPER_DATA),
        .COEF_DATA  (COEF_DATA),
        .DSP_ENABLE (DSP_ENABLE),
        .DSP_CLR    (DSP_CLR),
        .MAC_OUT    (MAC_OUT),
        .RESULT     (RESULT),
        .RESULT_VLD (RESULT_VLD),
        .RESULT_RDY (RESULT_RDY)
    );

    always #5 CLOCK = ~CLOCK;

    // Registered MAC: clear loads the product, otherwise accumulate.
    logic signed [63:0] mac_acc = '0;
    logic signed [63:0] mac_prod;
    assign mac_prod = $signed(OPER_DATA) * $signed(COEF_DATA);
    assign MAC_OUT  = mac_acc;
    always @(posedge CLOCK) begin
        if (DSP_ENABLE) mac_acc <= DSP_CLR ? mac_prod : mac_acc + mac_prod;
    end

    // Enable/clear activity counters; clear must sit on the first enabled cycle of a burst.
    int   en_cnt  = 0;
    int   clr_cnt = 0;
    int   clr_bad = 0;
    logic prev_en = 1'b0;
    always @(negedge CLOCK) begin
        if (DSP_ENABLE) en_cnt++;
        if (DSP_CLR) clr_cnt++;
        if (DSP_CLR && (!DSP_ENABLE || prev_en)) clr_bad++;
        if (DSP_ENABLE && !prev_en && !DSP_CLR) clr_bad++;
        prev_en = DSP_ENABLE;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge CLOCK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic timeout(input string tag);
        n_vec++;
        n_err++;
        $error("FAIL %s observed=timeout expected=event", tag);
    endtask

    task automatic write_coef(input logic [3:0] a, input logic [15:0] d);
        COEF_WE    = 1'b1;
        COEF_ADDR  = a;
        COEF_WDATA = d;
        tick;
        COEF_WE    = 1'b0;
    endtask

    // Present a sample and complete its handshake; returns in the first RUN cycle.
    task automatic start_sample(input logic [15:0] x);
        int g;
        g = 0;
        SAMPLE_IN  = x;
        SAMPLE_VLD = 1'b1;
        while (SAMPLE_RDY !== 1'b1 && g < 50) begin
            tick;
            g++;
        end
        if (g >= 50) timeout("sample_rdy_wait");
        tick;
        SAMPLE_VLD = 1'b0;
    endtask

    // Wait for the result (lat counts cycles from the handshake edge), then accept it.
    task automatic finish_pass(output logic [63:0] res, output int lat);
        lat = 1;
        while (RESULT_VLD !== 1'b1 && lat < 50) begin
            tick;
            lat++;
        end
        if (lat >= 50) timeout("result_vld_wait");
        res        = RESULT;
        RESULT_RDY = 1'b1;
        tick;
        RESULT_RDY = 1'b0;
    endtask

    task automatic check_reset_outputs(input string pfx);
        chk({pfx, "_sample_rdy"}, {63'd0, SAMPLE_RDY}, 64'd1);
        chk({pfx, "_result_vld"}, {63'd0, RESULT_VLD}, 64'd0);
        chk({pfx, "_dsp_enable"}, {63'd0, DSP_ENABLE}, 64'd0);
        chk({pfx, "_dsp_clr"},    {63'd0, DSP_CLR},    64'd0);
        chk({pfx, "_oper_data"},  {32'd0, OPER_DATA},  64'd0);
        chk({pfx, "_coef_data"},  {32'd0, COEF_DATA},  64'd0);
        chk({pfx, "_result"},     RESULT,              64'd0);
    endtask

    initial begin
        logic [63:0] res;
        int          lat;
        int          g;
        int          en0, clr0, bad0;
        logic [15:0] imp_x [5];
        logic [63:0] imp_y [5];
        logic [15:0] b2b_x [3];
        logic [63:0] b2b_y [3];

        imp_x = '{16'd1, 16'd0, 16'd0, 16'd0, 16'd0};
        imp_y = '{64'd1, 64'd2, 64'd3, 64'd4, 64'd0};
        b2b_x = '{16'd1, 16'd2, 16'd3};
        b2b_y = '{64'd20, 64'd35, 64'd53};

        // Reset state
        CLR = 1'b1;
        tick;
        tick;
        check_reset_outputs("reset");
        CLR = 1'b0;
        tick;

        // Impulse response with c = 1,2,3,4
        write_coef(4'd0, 16'd1);
        write_coef(4'd1, 16'd2);
        write_coef(4'd2, 16'd3);
        write_coef(4'd3, 16'd4);
        for (int i = 0; i < 5; i++) begin
            start_sample(imp_x[i]);
            finish_pass(res, lat);
            chk($sformatf("impulse_y%0d", i), res, imp_y[i]);
            if (i == 0) chk("impulse_latency", 64'(lat), 64'd6);
        end

        // Sign extension: -1 * 3
        write_coef(4'd0, 16'd3);
        write_coef(4'd1, 16'd0);
        write_coef(4'd2, 16'd0);
        write_coef(4'd3, 16'd0);
        start_sample(16'hFFFF);
        chk("sext_oper_tap0", {32'd0, OPER_DATA}, 64'h0000_0000_FFFF_FFFF);
        chk("sext_coef_tap0", {32'd0, COEF_DATA}, 64'd3);
        chk("sext_clr_tap0",  {63'd0, DSP_CLR},   64'd1);
        finish_pass(res, lat);
        chk("sext_result", res, 64'hFFFF_FFFF_FFFF_FFFD);

        // Backpressure: delay line becomes 5,-1,0,0 -> y = 5 - 2 = 3
        write_coef(4'd0, 16'd1);
        write_coef(4'd1, 16'd2);
        write_coef(4'd2, 16'd3);
        write_coef(4'd3, 16'd4);
        start_sample(16'd5);
        SAMPLE_IN  = 16'd10;
        SAMPLE_VLD = 1'b1;
        g = 0;
        while (RESULT_VLD !== 1'b1 && g < 50) begin
            tick;
            g++;
        end
        if (g >= 50) timeout("bp_result_wait");
        for (int i = 0; i < 10; i++) begin
            chk("bp_result_stable", RESULT, 64'd3);
            chk("bp_sample_rdy",    {63'd0, SAMPLE_RDY}, 64'd0);
            chk("bp_dsp_enable",    {63'd0, DSP_ENABLE}, 64'd0);
            tick;
        end
        RESULT_RDY = 1'b1;
        tick;
        RESULT_RDY = 1'b0;
        chk("bp_idle_rdy",     {63'd0, SAMPLE_RDY}, 64'd1);
        chk("bp_idle_vld_low", {63'd0, RESULT_VLD}, 64'd0);
        tick;
        SAMPLE_VLD = 1'b0;
        chk("bp_next_enable", {63'd0, DSP_ENABLE}, 64'd1);
        chk("bp_next_clr",    {63'd0, DSP_CLR},    64'd1);
        chk("bp_next_oper",   {32'd0, OPER_DATA},  64'd10);
        // delay line 10,5,-1,0 -> 10 + 10 - 3 = 17
        finish_pass(res, lat);
        chk("bp_next_result",  res, 64'd17);
        chk("bp_next_latency", 64'(lat), 64'd6);

        // Coefficient write gating: write during RUN and out-of-range write in IDLE
        start_sample(16'd1);
        write_coef(4'd1, 16'd7);
        finish_pass(res, lat);
        chk("gate_run_write", res, 64'd32);
        write_coef(4'd5, 16'd100);
        start_sample(16'd0);
        finish_pass(res, lat);
        chk("gate_addr_write", res, 64'd52);

        // Reset during tap 2 (delay line 3,0,1,10)
        start_sample(16'd3);
        tick;
        tick;
        chk("rst_tap2_enable", {63'd0, DSP_ENABLE}, 64'd1);
        chk("rst_tap2_oper",   {32'd0, OPER_DATA},  64'd1);
        CLR = 1'b1;
        #1;
        check_reset_outputs("midrun");
        tick;
        CLR = 1'b0;
        write_coef(4'd0, 16'd6);
        write_coef(4'd1, 16'd2);
        write_coef(4'd2, 16'd3);
        write_coef(4'd3, 16'd4);
        start_sample(16'd7);
        finish_pass(res, lat);
        chk("rst_cleared_line", res, 64'd42);

        // DSP_CLR placement over three back-to-back passes
        en0  = en_cnt;
        clr0 = clr_cnt;
        bad0 = clr_bad;
        for (int i = 0; i < 3; i++) begin
            start_sample(b2b_x[i]);
            finish_pass(res, lat);
            chk($sformatf("b2b_y%0d", i), res, b2b_y[i]);
            chk($sformatf("b2b_lat%0d", i), 64'(lat), 64'd6);
        end
        chk("b2b_enable_cycles", 64'(en_cnt - en0),   64'd12);
        chk("b2b_clr_pulses",    64'(clr_cnt - clr0), 64'd3);
        chk("b2b_clr_misplaced", 64'(clr_bad - bad0), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
